load_store_unit: RTL and testbench

- Sequential memory stage directly upstream of the writeback data-memory mux.
- Takes the ALU-computed effective address, the rs2 store data and the load/store funct3.
- Runs a valid/ready transaction on the data bus, stalling the core until it completes.
- Returns the aligned, sign- or zero-extended load word on rdata, which feeds the writeback mux's wb_sel=2'b10 input.

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/lsu_if.sv | 20 ++
 rtl/lsu_align.sv | 76 +++++++
 rtl/load_store_unit.sv | 115 +++++++++++
 tb/tb_load_store_unit.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: funct3 codes, FSM states,
// byte-enable patterns and the latched bus request payload.
package lsu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [BE_W-1:0] BE_NONE = 4'b0000;
  localparam logic [BE_W-1:0] BE_BYTE = 4'b0001;
  localparam logic [BE_W-1:0] BE_HALF = 4'b0011;
  localparam logic [BE_W-1:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [BE_W-1:0] be;
  } lsu_req_t;

endpackage

// File: rtl/lsu_if.sv
// Data-bus valid/ready channel between the load/store unit (master) and memory (slave).
interface lsu_if;
  logic        bus_valid;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: access legality, store lane replication / byte enables,
// and load byte/halfword extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic            mem_we,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] store_data,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_addr_lo,
  input  logic [XLEN-1:0] ld_word,
  output logic            legal_c,
  output logic [XLEN-1:0] wdata_c,
  output logic [BE_W-1:0] be_c,
  output logic [XLEN-1:0] load_data_c
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Unsigned loads have no store counterpart; halfword/word need natural alignment.
  always_comb begin
    legal_c = 1'b0;
    case (funct3)
      F3_LB:   legal_c = 1'b1;
      F3_LH:   legal_c = ~addr_lo[0];
      F3_LW:   legal_c = (addr_lo == 2'b00);
      F3_LBU:  legal_c = ~mem_we;
      F3_LHU:  legal_c = ~mem_we & ~addr_lo[0];
      default: legal_c = 1'b0;
    endcase
  end

  always_comb begin
    wdata_c = store_data;
    be_c    = BE_WORD;
    case (funct3)
      F3_LB: begin
        wdata_c = {4{store_data[7:0]}};
        be_c    = BE_BYTE << addr_lo;
      end
      F3_LH: begin
        wdata_c = {2{store_data[15:0]}};
        be_c    = BE_HALF << addr_lo;
      end
      default: begin
        wdata_c = store_data;
        be_c    = BE_WORD;
      end
    endcase
  end

  always_comb begin
    ld_byte = ld_word[7:0];
    case (ld_addr_lo)
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    ld_half = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
  end

  always_comb begin
    load_data_c = ld_word;
    case (ld_funct3)
      F3_LB:   load_data_c = {{24{ld_byte[7]}}, ld_byte};
      F3_LBU:  load_data_c = {24'd0, ld_byte};
      F3_LH:   load_data_c = {{16{ld_half[15]}}, ld_half};
      F3_LHU:  load_data_c = {16'd0, ld_half};
      default: load_data_c = ld_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: issues one valid/ready bus transaction per load/store, stalls the
// core until it completes or times out, and registers the extended load result.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        access_err,
  lsu_if.master       bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_e       state;
  lsu_req_t         req_q;
  logic             valid_q;
  logic [2:0]       ld_funct3;
  logic [1:0]       ld_addr_lo;
  logic [CNT_W-1:0] cnt;

  logic             legal_c;
  logic [XLEN-1:0]  wdata_c;
  logic [BE_W-1:0]  be_c;
  logic [XLEN-1:0]  load_data_c;

  lsu_align u_align (
    .mem_we      (mem_we),
    .funct3      (funct3),
    .addr_lo     (addr[1:0]),
    .store_data  (store_data),
    .ld_funct3   (ld_funct3),
    .ld_addr_lo  (ld_addr_lo),
    .ld_word     (bus.bus_rdata),
    .legal_c     (legal_c),
    .wdata_c     (wdata_c),
    .be_c        (be_c),
    .load_data_c (load_data_c)
  );

  // Stall must rise in the request cycle itself so the core holds the instruction.
  assign stall = (state == BUS) || ((state == IDLE) && mem_req && legal_c);

  assign bus.bus_valid = valid_q;
  assign bus.bus_we    = req_q.we;
  assign bus.bus_addr  = req_q.addr;
  assign bus.bus_wdata = req_q.wdata;
  assign bus.bus_be    = req_q.be;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_q      <= '0;
      valid_q    <= 1'b0;
      ld_funct3  <= 3'd0;
      ld_addr_lo <= 2'd0;
      cnt        <= '0;
      rdata      <= 32'd0;
      access_err <= 1'b0;
    end else begin
      access_err <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_req) begin
            if (legal_c) begin
              req_q.we    <= mem_we;
              req_q.addr  <= {addr[31:2], 2'b00};
              req_q.wdata <= wdata_c;
              req_q.be    <= be_c;
              ld_funct3   <= funct3;
              ld_addr_lo  <= addr[1:0];
              cnt         <= '0;
              valid_q     <= 1'b1;
              state       <= BUS;
            end else begin
              access_err  <= 1'b1;
            end
          end
        end
        BUS: begin
          // A ready on the final allowed cycle still completes the access.
          if (bus.bus_ready) begin
            if (!req_q.we) begin
              rdata <= load_data_c;
            end
            valid_q <= 1'b0;
            state   <= DONE;
          end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            valid_q    <= 1'b0;
            access_err <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (TIMEOUT_CYCLES=4): store lanes, load extension,
// illegal accesses, bus timeout and mid-transaction reset.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic        mem_we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] rdata;
  logic        stall;
  logic        access_err;

  int checks = 0;
  int errors = 0;

  int          st;
  int          nb;
  logic        cwe;
  logic [31:0] caddr;
  logic [31:0] cwdata;
  logic [3:0]  cbe;

  lsu_if bus ();

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .rdata      (rdata),
    .stall      (stall),
    .access_err (access_err),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd);
    mem_req    = 1'b1;
    mem_we     = we;
    funct3     = f3;
    addr       = a;
    store_data = sd;
  endtask

  task automatic idle();
    mem_req       = 1'b0;
    bus.bus_ready = 1'b0;
    tick();
  endtask

  // Acts as the memory slave: ready after 'waits' BUS cycles, bounded to 40 cycles.
  task automatic run_txn(input int waits, input logic [31:0] rd, output int stalled,
                         output int nbus, output logic we_o, output logic [31:0] addr_o,
                         output logic [31:0] wdata_o, output logic [3:0] be_o);
    stalled       = 0;
    nbus          = 0;
    we_o          = 1'bx;
    addr_o        = 'x;
    wdata_o       = 'x;
    be_o          = 'x;
    bus.bus_rdata = rd;
    bus.bus_ready = 1'b0;
    #1;
    for (int c = 0; c < 40 && stall === 1'b1; c++) begin
      stalled++;
      if (bus.bus_valid === 1'b1) begin
        if (nbus == 0) begin
          we_o    = bus.bus_we;
          addr_o  = bus.bus_addr;
          wdata_o = bus.bus_wdata;
          be_o    = bus.bus_be;
        end
        bus.bus_ready = (nbus >= waits);
        nbus++;
      end
      tick();
    end
    bus.bus_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    funct3        = 3'd0;
    addr          = 32'd0;
    store_data    = 32'd0;
    bus.bus_ready = 1'b0;
    bus.bus_rdata = 32'd0;
    tick();
    tick();
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_valid", 32'(bus.bus_valid), 32'd0);
    chk("rst_be", 32'(bus.bus_be), 32'd0);
    chk("rst_addr", bus.bus_addr, 32'd0);
    chk("rst_err", 32'(access_err), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    rst = 1'b0;

    // Ready while no request is outstanding has no effect.
    bus.bus_ready = 1'b1;
    tick();
    chk("idle_ready_valid", 32'(bus.bus_valid), 32'd0);
    chk("idle_ready_stall", 32'(stall), 32'd0);
    bus.bus_ready = 1'b0;

    // SW
    issue(1'b1, F3_LW, 32'h0000_1000, 32'hDEAD_BEEF);
    run_txn(0, 32'h0, st, nb, cwe, caddr, cwdata, cbe);
    chk("sw_stall", 32'(st), 32'd2);
    chk("sw_nbus", 32'(nb), 32'd1);
    chk("sw_addr", caddr, 32'h0000_1000);
    chk("sw_be", 32'(cbe), 32'h0000_000F);
    chk("sw_wdata", cwdata, 32'hDEAD_BEEF);
    chk("sw_we", 32'(cwe), 32'd1);
    chk("sw_err", 32'(access_err), 32'd0);
    chk("sw_rdata", rdata, 32'd0);
    chk("sw_done_valid", 32'(bus.bus_valid), 32'd0);
    idle();

    // SB
    issue(1'b1, F3_LB, 32'h0000_1003, 32'h0000_00A5);
    run_txn(0, 32'h0, st, nb, cwe, caddr, cwdata, cbe);
    chk("sb_be", 32'(cbe), 32'h0000_0008);
    chk("sb_wdata", cwdata, 32'hA5A5_A5A5);
    chk("sb_we", 32'(cwe), 32'd1);
    chk("sb_addr", caddr, 32'h0000_1000);
    idle();

    // SH upper half
    issue(1'b1, F3_LH, 32'h0000_1002, 32'h1234_ABCD);
    run_txn(0, 32'h0, st, nb, cwe, caddr, cwdata, cbe);
    chk("sh_be", 32'(cbe), 32'h0000_000C);
    chk("sh_wdata", cwdata, 32'hABCD_ABCD);
    idle();

    // LB with three wait cycles
    issue(1'b0, F3_LB, 32'h0000_2001, 32'h0);
    run_txn(3, 32'h1234_80FF, st, nb, cwe, caddr, cwdata, cbe);
    chk("lb_stall", 32'(st), 32'd5);
    chk("lb_nbus", 32'(nb), 32'd4);
    chk("lb_we", 32'(cwe), 32'd0);
    chk("lb_addr", caddr, 32'h0000_2000);
    chk("lb_rdata", rdata, 32'hFFFF_FF80);
    chk("lb_err", 32'(access_err), 32'd0);
    idle();

    // LBU, same access
    issue(1'b0, F3_LBU, 32'h0000_2001, 32'h0);
    run_txn(3, 32'h1234_80FF, st, nb, cwe, caddr, cwdata, cbe);
    chk("lbu_rdata", rdata, 32'h0000_0080);
    idle();

    // LHU lower half
    issue(1'b0, F3_LHU, 32'h0000_2000, 32'h0);
    run_txn(0, 32'h1234_F00D, st, nb, cwe, caddr, cwdata, cbe);
    chk("lhu_rdata", rdata, 32'h0000_F00D);
    idle();

    // LH upper half
    issue(1'b0, F3_LH, 32'h0000_2002, 32'h0);
    run_txn(0, 32'h8001_0000, st, nb, cwe, caddr, cwdata, cbe);
    chk("lh_rdata", rdata, 32'hFFFF_8001);
    chk("lh_stall", 32'(st), 32'd2);
    idle();

    // Misaligned LW
    issue(1'b0, F3_LW, 32'h0000_2002, 32'h0);
    #1;
    chk("mis_stall", 32'(stall), 32'd0);
    tick();
    chk("mis_err", 32'(access_err), 32'd1);
    chk("mis_valid", 32'(bus.bus_valid), 32'd0);
    chk("mis_rdata", rdata, 32'hFFFF_8001);
    mem_req = 1'b0;
    tick();
    chk("mis_err_pulse", 32'(access_err), 32'd0);
    chk("mis_valid2", 32'(bus.bus_valid), 32'd0);

    // Illegal funct3: store with unsigned code
    issue(1'b1, F3_LBU, 32'h0000_2000, 32'h0);
    #1;
    chk("ill_stall", 32'(stall), 32'd0);
    tick();
    chk("ill_err", 32'(access_err), 32'd1);
    chk("ill_valid", 32'(bus.bus_valid), 32'd0);
    idle();

    // Timeout: ready never arrives
    issue(1'b0, F3_LW, 32'h0000_3000, 32'h0);
    run_txn(100, 32'h5555_5555, st, nb, cwe, caddr, cwdata, cbe);
    chk("to_nbus", 32'(nb), 32'd4);
    chk("to_stall", 32'(st), 32'd5);
    chk("to_err", 32'(access_err), 32'd1);
    chk("to_rdata", rdata, 32'hFFFF_8001);
    chk("to_valid", 32'(bus.bus_valid), 32'd0);
    idle();
    chk("to_err_pulse", 32'(access_err), 32'd0);
    chk("to_idle_stall", 32'(stall), 32'd0);

    // Reset during the second BUS cycle
    issue(1'b0, F3_LW, 32'h0000_4000, 32'h0);
    bus.bus_ready = 1'b0;
    tick();
    chk("rb_valid_bus1", 32'(bus.bus_valid), 32'd1);
    tick();
    rst     = 1'b1;
    mem_req = 1'b0;
    tick();
    chk("rb_valid", 32'(bus.bus_valid), 32'd0);
    chk("rb_stall", 32'(stall), 32'd0);
    chk("rb_rdata", rdata, 32'd0);
    rst = 1'b0;
    issue(1'b0, F3_LW, 32'h0000_4004, 32'h0);
    run_txn(1, 32'hCAFE_F00D, st, nb, cwe, caddr, cwdata, cbe);
    chk("rb_lw_rdata", rdata, 32'hCAFE_F00D);
    chk("rb_lw_stall", 32'(st), 32'd3);
    chk("rb_lw_addr", caddr, 32'h0000_4004);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
